hazard_branch_ctrl: RTL and testbench
=====================================

Name: hazard_branch_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Resolves branches in MEM using the branch-AND-zero decision (MEM_Branch & MEM_Zero).
- Detects load-use hazards between the EX and ID stages, and handles ID-stage jumps.
- Drives PC/IF-ID write enables, stage flushes, the ID/EX bubble and PC source select; keeps saturating stall/flush performance counters.

Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal range 1..7.
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Rt  in  5  destination register of the EX load.
- ID_Rs  in  5  ID source register 1.
- ID_Rt  in  5  ID source register 2.
- ID_UsesRs  in  1  ID instruction reads Rs.
- ID_UsesRt  in  1  ID instruction reads Rt.
- ID_Jump  in  1  ID instruction is an unconditional jump.
- MEM_Branch  in  1  MEM instruction is a conditional branch.
- MEM_Zero  in  1  ALU zero flag carried to MEM.
- PCWrite  out  1  PC register write enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEX_Bubble  out  1  zero the ID/EX control fields.
- IFID_Flush  out  1  clear IF/ID.
- IDEX_Flush  out  1  clear ID/EX.
- EXMEM_Flush  out  1  clear EX/MEM control.
- PCSrc  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target, 11 unused.
- StallCount  out  CNT_W  cycles with IDEX_Bubble=1 (saturating).
- FlushCount  out  CNT_W  redirect events, branch or jump (saturating).

Behaviour:
- Clk and Rst are fixed: one clock; reset is asynchronous and active-high.
- State: RUN, STALL; 3-bit remaining-stall counter rem.
- While Rst=1, all of the following hold immediately:
  - state=RUN, rem=0, StallCount=0, FlushCount=0.
  - PCWrite=0, IFIDWrite=0, IDEX_Bubble=0, all flushes=0, PCSrc=00.
- Outputs are combinational from state, rem and current inputs (zero latency). Counters and state update on the rising edge.
- Definitions:
  - taken = MEM_Branch & MEM_Zero.
  - lu = EX_MemRead & (EX_Rt != 0) & ((ID_UsesRs & ID_Rs==EX_Rt) | (ID_UsesRt & ID_Rt==EX_Rt)).
- Priority, highest first:
  1. taken, in any state:
     - Outputs: PCSrc=01, PCWrite=1, IFIDWrite=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, IDEX_Bubble=0.
     - Next state=RUN, rem=0; any pending stall is aborted because the stalled instruction is squashed.
     - FlushCount+1.
  2. STALL state (no taken):
     - Outputs: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, PCSrc=00, no flushes.
     - rem-1; if rem==1, next state=RUN.
     - ID_Jump is ignored; it is acted on once the stall ends.
  3. RUN with lu:
     - Outputs: same as STALL.
     - If STALL_CYCLES>1: next state=STALL, rem=STALL_CYCLES-1. Otherwise stay in RUN.
  4. RUN with ID_Jump:
     - Outputs: PCSrc=10, PCWrite=1, IFIDWrite=1, IFID_Flush=1.
     - FlushCount+1.
  5. Otherwise:
     - Outputs: PCWrite=1, IFIDWrite=1, all others 0, PCSrc=00.
- lu and ID_Jump together in RUN: the stall wins; the jump is serviced when ID is released.
- StallCount increments every cycle IDEX_Bubble=1.
- Both counters saturate at 2^CNT_W-1; no wrap-around.
- Rst asserted mid-stall returns to RUN immediately; no residual bubble after Rst deasserts.
- X-free: every output is driven in every branch.

Decomposition:
- Shared package/header holds:
  - PCSrc encodings: PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JMP=2'b10.
  - State encodings: ST_RUN, ST_STALL.
  - REG_ZERO=5'd0.
- One sub-module: load_use_detect. It is purely combinational, produces lu from the EX/ID register fields, and is reused by the forwarding unit tests.
- FSM and counters stay in the top module.

Test Plan:
1. Reset/idle: assert Rst mid-cycle, release with all inputs 0 -> outputs zero during reset; afterwards PCWrite=IFIDWrite=1, PCSrc=00, counters 0.
2. Load-use, STALL_CYCLES=1: EX_MemRead=1, EX_Rt=5, ID_Rs=5, ID_UsesRs=1 for one cycle, then load leaves EX -> exactly 1 cycle PCWrite=0/IDEX_Bubble=1, StallCount=1. Repeat with EX_Rt=0 -> no stall.
3. STALL_CYCLES=2: same hazard, hazard inputs dropped after cycle 1 -> 2 consecutive bubble cycles, StallCount=2, then RUN.
4. Branch aborts stall: STALL_CYCLES=3, hazard, then taken (MEM_Branch=1, MEM_Zero=1) in the second stall cycle -> that cycle PCSrc=01 with three flushes and PCWrite=1; next cycle normal, StallCount=1, FlushCount=1. MEM_Branch=1 with MEM_Zero=0 -> no flush.
5. Jump plus hazard same cycle: ID_Jump=1 with lu=1 -> stall first; next cycle (lu=0) PCSrc=10, IFID_Flush=1, FlushCount=1.
6. Saturation: CNT_W=4, hold lu=1 for 20 cycles -> StallCount stops at 15.

Source files
------------

// File: rtl/hazard_branch_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller and its helpers.
package hazard_branch_ctrl_pkg;

  // PC source select encodings
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // Register 0 is hard-wired to zero, so it never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Controller FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Bundle of pipeline control outputs produced each cycle
  typedef struct packed {
    logic       pcwrite;
    logic       ifidwrite;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/hazard_branch_ctrl_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// register an EX-stage load is about to write.
module load_use_detect
  import hazard_branch_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  // A match only matters when the ID instruction actually reads that operand
  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rt);
    rt_hit = id_uses_rt && (id_rt == ex_rt);
    lu     = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Pipeline sequencing controller: branch resolution in MEM, load-use stalls,
// ID-stage jumps, plus saturating stall/flush performance counters.
module hazard_branch_ctrl
  import hazard_branch_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [1:0]       PCSrc,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // Extra stall cycles spent in ST_STALL after the detecting cycle
  localparam logic [2:0]       REM_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  ctrl_t            ctrl;
  logic             redirect;
  logic             taken;
  logic             lu;

  load_use_detect u_lud (
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_Rt),
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rs  (ID_UsesRs),
    .id_uses_rt  (ID_UsesRt),
    .lu          (lu)
  );

  assign taken = MEM_Branch & MEM_Zero;

  // Prioritised next-state and control decode: taken branch > stall > load-use > jump
  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    rem_d    = rem_q;
    redirect = 1'b0;
    if (Rst) begin
      // Everything held quiet while reset is asserted
      state_d = ST_RUN;
      rem_d   = '0;
    end else if (taken) begin
      // Squashes anything younger, including a stalled instruction in ID
      ctrl.pcsrc       = PCSRC_BR;
      ctrl.pcwrite     = 1'b1;
      ctrl.ifidwrite   = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      state_d          = ST_RUN;
      rem_d            = '0;
      redirect         = 1'b1;
    end else if (state_q == ST_STALL) begin
      // Jumps wait in ID until the stall drains
      ctrl.idex_bubble = 1'b1;
      if (rem_q <= 3'd1) begin
        state_d = ST_RUN;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - 3'd1;
      end
    end else if (lu) begin
      // First bubble is issued now; any further ones come from ST_STALL
      ctrl.idex_bubble = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = ST_STALL;
        rem_d   = REM_INIT;
      end
    end else if (ID_Jump) begin
      ctrl.pcsrc      = PCSRC_JMP;
      ctrl.pcwrite    = 1'b1;
      ctrl.ifidwrite  = 1'b1;
      ctrl.ifid_flush = 1'b1;
      redirect        = 1'b1;
    end else begin
      ctrl.pcsrc     = PCSRC_SEQ;
      ctrl.pcwrite   = 1'b1;
      ctrl.ifidwrite = 1'b1;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.idex_bubble && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State, stall counter and performance counter registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCWrite     = ctrl.pcwrite;
  assign IFIDWrite   = ctrl.ifidwrite;
  assign IDEX_Bubble = ctrl.idex_bubble;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Flush  = ctrl.idex_flush;
  assign EXMEM_Flush = ctrl.exmem_flush;
  assign PCSrc       = ctrl.pcsrc;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_branch_ctrl.sv
// Directed bench for hazard_branch_ctrl: four instances with different
// STALL_CYCLES / CNT_W share one input set; one is selected for checking.
module tb_hazard_branch_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       EX_MemRead = 1'b0;
  logic [4:0] EX_Rt = '0;
  logic [4:0] ID_Rs = '0;
  logic [4:0] ID_Rt = '0;
  logic       ID_UsesRs = 1'b0;
  logic       ID_UsesRt = 1'b0;
  logic       ID_Jump = 1'b0;
  logic       MEM_Branch = 1'b0;
  logic       MEM_Zero = 1'b0;

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        pcw;
    logic        ifidw;
    logic        bub;
    logic [2:0]  fl;
    logic [1:0]  pcsrc;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  // Expected {PCWrite, IFIDWrite, IDEX_Bubble, IFID/IDEX/EXMEM flush, PCSrc}
  localparam logic [7:0] E_RUN  = 8'b110_000_00;
  localparam logic [7:0] E_BUB  = 8'b001_000_00;
  localparam logic [7:0] E_BR   = 8'b110_111_01;
  localparam logic [7:0] E_JMP  = 8'b110_100_10;
  localparam logic [7:0] E_ZERO = 8'b000_000_00;

  // Input controls {EX_MemRead, ID_UsesRs, ID_UsesRt, ID_Jump, MEM_Branch, MEM_Zero}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_LDRS  = 6'b110000;
  localparam logic [5:0] I_LDRT  = 6'b101000;
  localparam logic [5:0] I_JMP   = 6'b000100;
  localparam logic [5:0] I_TAKEN = 6'b000011;
  localparam logic [5:0] I_BRNT  = 6'b000010;

  logic        pcw [4];
  logic        ifw [4];
  logic        bub [4];
  logic        ffi [4];
  logic        ffd [4];
  logic        ffm [4];
  logic [1:0]  pcs [4];
  logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
  logic [3:0]  sc3, fc3;

  hazard_branch_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u_sc1 (
    .Clk(Clk), .Rst(Rst), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .PCWrite(pcw[0]), .IFIDWrite(ifw[0]),
    .IDEX_Bubble(bub[0]), .IFID_Flush(ffi[0]), .IDEX_Flush(ffd[0]), .EXMEM_Flush(ffm[0]),
    .PCSrc(pcs[0]), .StallCount(sc0), .FlushCount(fc0));

  hazard_branch_ctrl #(.STALL_CYCLES(2), .CNT_W(16)) u_sc2 (
    .Clk(Clk), .Rst(Rst), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .PCWrite(pcw[1]), .IFIDWrite(ifw[1]),
    .IDEX_Bubble(bub[1]), .IFID_Flush(ffi[1]), .IDEX_Flush(ffd[1]), .EXMEM_Flush(ffm[1]),
    .PCSrc(pcs[1]), .StallCount(sc1), .FlushCount(fc1));

  hazard_branch_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_sc3 (
    .Clk(Clk), .Rst(Rst), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .PCWrite(pcw[2]), .IFIDWrite(ifw[2]),
    .IDEX_Bubble(bub[2]), .IFID_Flush(ffi[2]), .IDEX_Flush(ffd[2]), .EXMEM_Flush(ffm[2]),
    .PCSrc(pcs[2]), .StallCount(sc2), .FlushCount(fc2));

  hazard_branch_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_sat (
    .Clk(Clk), .Rst(Rst), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .PCWrite(pcw[3]), .IFIDWrite(ifw[3]),
    .IDEX_Bubble(bub[3]), .IFID_Flush(ffi[3]), .IDEX_Flush(ffd[3]), .EXMEM_Flush(ffm[3]),
    .PCSrc(pcs[3]), .StallCount(sc3), .FlushCount(fc3));

  int   sel = 0;
  obs_t obs;

  always_comb begin
    obs = '0;
    obs.pcw   = pcw[sel];
    obs.ifidw = ifw[sel];
    obs.bub   = bub[sel];
    obs.fl    = {ffi[sel], ffd[sel], ffm[sel]};
    obs.pcsrc = pcs[sel];
    case (sel)
      0:       begin obs.sc = sc0;          obs.fc = fc0;          end
      1:       begin obs.sc = sc1;          obs.fc = fc1;          end
      2:       begin obs.sc = sc2;          obs.fc = fc2;          end
      default: begin obs.sc = {12'd0, sc3}; obs.fc = {12'd0, fc3}; end
    endcase
  end

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic check_out(input string tag);
    obs_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s (dut %0d): got pcw=%b ifw=%b bub=%b fl=%b pcsrc=%b sc=%0d fc=%0d, expected pcw=%b ifw=%b bub=%b fl=%b pcsrc=%b sc=%0d fc=%0d",
             tag, sel, obs.pcw, obs.ifidw, obs.bub, obs.fl, obs.pcsrc, obs.sc, obs.fc,
             e.pcw, e.ifidw, e.bub, e.fl, e.pcsrc, e.sc, e.fc);
    end
  endtask

  // One cycle: drive inputs after the falling edge, record the expectation, sample
  task automatic cyc(input string tag, input logic [5:0] ctl, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [7:0] eo,
                     input int sc, input int fc);
    @(negedge Clk);
    {EX_MemRead, ID_UsesRs, ID_UsesRt, ID_Jump, MEM_Branch, MEM_Zero} = ctl;
    EX_Rt = ert;
    ID_Rs = rs;
    ID_Rt = rt;
    exp_q.push_back({eo, 16'(sc), 16'(fc)});
    #2;
    check_out(tag);
  endtask

  // Assert reset part-way through a cycle, check the quiet outputs, release
  task automatic do_rst(input string tag);
    @(negedge Clk);
    {EX_MemRead, ID_UsesRs, ID_UsesRt, ID_Jump, MEM_Branch, MEM_Zero} = I_NONE;
    EX_Rt = '0;
    ID_Rs = '0;
    ID_Rt = '0;
    #2 Rst = 1'b1;
    exp_q.push_back({E_ZERO, 16'd0, 16'd0});
    #1;
    check_out(tag);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    sel = 0;
    do_rst("rst");
    cyc("idle", I_NONE, 0, 0, 0, E_RUN, 0, 0);

    // Load-use with a single bubble
    cyc("lu_rs",      I_LDRS, 5, 5, 0, E_BUB, 0, 0);
    cyc("lu_rs_rel",  I_NONE, 0, 0, 0, E_RUN, 1, 0);
    cyc("lu_r0",      I_LDRS, 0, 0, 0, E_RUN, 1, 0);
    cyc("lu_rt",      I_LDRT, 7, 3, 7, E_BUB, 1, 0);
    cyc("lu_rt_rel",  I_NONE, 0, 0, 0, E_RUN, 2, 0);
    cyc("lu_nouse",   6'b100000, 5, 5, 5, E_RUN, 2, 0);
    cyc("lu_miss",    I_LDRS, 5, 6, 0, E_RUN, 2, 0);
    cyc("lu_noload",  6'b011000, 5, 5, 5, E_RUN, 2, 0);

    // Two-bubble stall; a jump arriving mid-stall waits its turn
    sel = 1;
    do_rst("rst_sc2");
    cyc("sc2_hz",     I_LDRS, 5, 5, 0, E_BUB, 0, 0);
    cyc("sc2_st",     I_NONE, 0, 0, 0, E_BUB, 1, 0);
    cyc("sc2_run",    I_NONE, 0, 0, 0, E_RUN, 2, 0);
    cyc("sc2_hzjmp",  I_LDRS | I_JMP, 5, 5, 0, E_BUB, 2, 0);
    cyc("sc2_stjmp",  I_JMP, 0, 0, 0, E_BUB, 3, 0);
    cyc("sc2_jmp",    I_JMP, 0, 0, 0, E_JMP, 4, 0);
    cyc("sc2_after",  I_NONE, 0, 0, 0, E_RUN, 4, 1);

    // Taken branch aborts a three-bubble stall
    sel = 2;
    do_rst("rst_sc3");
    cyc("sc3_hz",     I_LDRS, 5, 5, 0, E_BUB, 0, 0);
    cyc("br_abort",   I_TAKEN, 0, 0, 0, E_BR, 1, 0);
    cyc("post_br",    I_NONE, 0, 0, 0, E_RUN, 1, 1);
    cyc("br_ntaken",  I_BRNT, 0, 0, 0, E_RUN, 1, 1);
    cyc("br_vs_lu",   I_LDRS | I_TAKEN, 5, 5, 0, E_BR, 1, 1);
    cyc("post_br2",   I_NONE, 0, 0, 0, E_RUN, 1, 2);
    cyc("sc3_hz2",    I_LDRT, 9, 0, 9, E_BUB, 1, 2);
    cyc("sc3_st1",    I_NONE, 0, 0, 0, E_BUB, 2, 2);
    cyc("sc3_st2",    I_NONE, 0, 0, 0, E_BUB, 3, 2);
    cyc("sc3_run",    I_NONE, 0, 0, 0, E_RUN, 4, 2);
    cyc("sc3_hz3",    I_LDRS, 5, 5, 0, E_BUB, 4, 2);
    cyc("sc3_st3",    I_NONE, 0, 0, 0, E_BUB, 5, 2);
    do_rst("rst_mid_stall");
    cyc("post_rst",   I_NONE, 0, 0, 0, E_RUN, 0, 0);
    cyc("post_rst2",  I_NONE, 0, 0, 0, E_RUN, 0, 0);

    // Jump and hazard in the same cycle: stall first, then the jump
    sel = 0;
    do_rst("rst_jmp");
    cyc("jmp_lu",     I_LDRS | I_JMP, 5, 5, 0, E_BUB, 0, 0);
    cyc("jmp_served", I_JMP, 0, 0, 0, E_JMP, 1, 0);
    cyc("jmp_after",  I_NONE, 0, 0, 0, E_RUN, 1, 1);

    // Counter saturation with a 4-bit counter
    sel = 3;
    do_rst("rst_sat");
    for (int i = 0; i < 20; i++)
      cyc("sat_stall", I_LDRS, 5, 5, 0, E_BUB, (i > 15) ? 15 : i, 0);
    cyc("sat_stall_end", I_NONE, 0, 0, 0, E_RUN, 15, 0);
    for (int i = 0; i < 20; i++)
      cyc("sat_flush", I_JMP, 0, 0, 0, E_JMP, 15, (i > 15) ? 15 : i);
    cyc("sat_flush_end", I_NONE, 0, 0, 0, E_RUN, 15, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
